// File: rtl/scoreboard_pkg.sv
// rtl/scoreboard_pkg.sv - shared types and defaults for the register scoreboard
package scoreboard_pkg;

  localparam int REG_IDX_W    = 5;
  localparam int NUM_REGS_DEF = 32;
  localparam int CNT_W_DEF    = 2;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } sb_state_t;

endpackage

// File: rtl/sb_counter.sv
// rtl/sb_counter.sv - per-register outstanding-write counter, floors at zero
module sb_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             underflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: clear wins, simultaneous inc/dec cancel, never wrap either way
  always_comb begin
    cnt_d     = cnt_q;
    underflow = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else begin
      underflow = dec && (cnt_q == '0);
      if (inc && !dec) begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
      end else if (dec && !inc) begin
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
      end
    end
  end

  // Count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - issue-side register scoreboard (stall counter under SCOREBOARD_STALL_CNT_EN)
module reg_scoreboard
  import scoreboard_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 issue_valid,
  output logic                 issue_ready,
  input  logic [REG_IDX_W-1:0] issue_rs1,
  input  logic [REG_IDX_W-1:0] issue_rs2,
  input  logic                 issue_rs1_used,
  input  logic                 issue_rs2_used,
  input  logic [REG_IDX_W-1:0] issue_rd,
  input  logic                 issue_RegWrite,
  input  logic                 wb_valid,
  input  logic                 wb_RegWrite,
  input  logic [REG_IDX_W-1:0] wb_rd,
  input  logic                 flush,
  output logic [NUM_REGS-1:0]  pending_mask,
  output logic                 busy,
  output logic                 err_underflow,
  output logic [31:0]          stall_cycles
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  sb_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt [NUM_REGS];
  logic [NUM_REGS-1:0] uf;
  logic fire, retire, src_haz, waw_haz;
  logic err_underflow_q, err_underflow_d;

  assign cnt[0] = '0;
  assign uf[0]  = 1'b0;
  assign pending_mask[0] = 1'b0;

  // Hazards look only at registered counts, so wb_* never reaches issue_ready
  always_comb begin
    src_haz = (issue_rs1_used && (issue_rs1 != '0) && (cnt[issue_rs1] != '0)) ||
              (issue_rs2_used && (issue_rs2 != '0) && (cnt[issue_rs2] != '0));
    waw_haz = issue_RegWrite && (issue_rd != '0) && (cnt[issue_rd] == CNT_MAX);
    issue_ready = (state_q != FLUSH) && !flush && !src_haz && !waw_haz;
  end

  assign fire   = issue_valid && issue_ready;
  assign retire = wb_valid && wb_RegWrite && (wb_rd != '0) && !flush && (state_q != FLUSH);

  for (genvar i = 1; i < NUM_REGS; i++) begin : g_cnt
    logic inc_i, dec_i;
    assign inc_i = fire && issue_RegWrite && (issue_rd == REG_IDX_W'(i));
    assign dec_i = retire && (wb_rd == REG_IDX_W'(i));
    sb_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk       (clk),
      .rst       (rst),
      .inc       (inc_i),
      .dec       (dec_i),
      .clr       (flush),
      .cnt       (cnt[i]),
      .underflow (uf[i])
    );
    assign pending_mask[i] = (cnt[i] != '0);
  end

  assign busy = |pending_mask;

  // Next state: flush dominates; a stalled instruction returns to RUN once it fires
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (flush) state_d = FLUSH;
               else if (issue_valid && !issue_ready) state_d = STALL;
      STALL:   if (flush) state_d = FLUSH;
               else if (fire) state_d = RUN;
      FLUSH:   state_d = flush ? FLUSH : RUN;
      default: state_d = RUN;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  // Sticky underflow flag, cleared only by reset
  always_comb err_underflow_d = err_underflow_q | (|uf);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_underflow_q <= 1'b0;
    else     err_underflow_q <= err_underflow_d;
  end

  assign err_underflow = err_underflow_q;

`ifdef SCOREBOARD_STALL_CNT_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;

  // Free-running count of cycles decode was held off
  always_comb stall_cycles_d = (issue_valid && !issue_ready) ? stall_cycles_q + 32'd1 : stall_cycles_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cycles_q <= '0;
    else     stall_cycles_q <= stall_cycles_d;
  end

  assign stall_cycles = stall_cycles_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_reg_scoreboard.sv
// tb/tb_reg_scoreboard.sv - randomized self-checking bench for reg_scoreboard
module tb_reg_scoreboard;

  localparam int MAXC = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid, issue_ready;
  logic [4:0]  issue_rs1, issue_rs2, issue_rd;
  logic        issue_rs1_used, issue_rs2_used, issue_RegWrite;
  logic        wb_valid, wb_RegWrite;
  logic [4:0]  wb_rd;
  logic        flush;
  logic [31:0] pending_mask;
  logic        busy, err_underflow;
  logic [31:0] stall_cycles;

  int checks = 0;
  int failures = 0;

  int          m_cnt [32];
  bit          m_err;
  bit          m_blackout;
  logic [31:0] m_stall;

  reg_scoreboard dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_rs1_used(issue_rs1_used), .issue_rs2_used(issue_rs2_used),
    .issue_rd(issue_rd), .issue_RegWrite(issue_RegWrite),
    .wb_valid(wb_valid), .wb_RegWrite(wb_RegWrite), .wb_rd(wb_rd),
    .flush(flush), .pending_mask(pending_mask), .busy(busy),
    .err_underflow(err_underflow), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    foreach (m_cnt[i]) m_cnt[i] = 0;
    m_err = 0;
    m_blackout = 0;
    m_stall = '0;
  endtask

  function automatic bit model_ready();
    if (flush || m_blackout) return 0;
    if (issue_rs1_used && issue_rs1 != 0 && m_cnt[issue_rs1] != 0) return 0;
    if (issue_rs2_used && issue_rs2 != 0 && m_cnt[issue_rs2] != 0) return 0;
    if (issue_RegWrite && issue_rd != 0 && m_cnt[issue_rd] >= MAXC) return 0;
    return 1;
  endfunction

  task automatic check_outputs();
    logic [31:0] em;
    em = '0;
    for (int i = 1; i < 32; i++) em[i] = (m_cnt[i] != 0);
    check("pending_mask", 64'(pending_mask), 64'(em));
    check("busy", 64'(busy), 64'(|em));
    check("err_underflow", 64'(err_underflow), 64'(m_err));
    check("issue_ready", 64'(issue_ready), 64'(model_ready()));
    check("stall_cycles", 64'(stall_cycles), 64'(m_stall));
  endtask

  // Reference behaviour for one clock edge, from the current inputs
  task automatic model_step();
    bit rdy, fire, inc, ret;
    rdy  = model_ready();
    fire = issue_valid && rdy;
`ifdef SCOREBOARD_STALL_CNT_EN
    if (issue_valid && !rdy) m_stall = m_stall + 32'd1;
`endif
    if (flush) begin
      foreach (m_cnt[i]) m_cnt[i] = 0;
    end else begin
      inc = fire && issue_RegWrite && issue_rd != 0;
      ret = wb_valid && wb_RegWrite && wb_rd != 0 && !m_blackout;
      if (ret && m_cnt[wb_rd] == 0) m_err = 1;
      if (!(inc && ret && issue_rd == wb_rd)) begin
        if (inc) m_cnt[issue_rd]++;
        if (ret && m_cnt[wb_rd] > 0) m_cnt[wb_rd]--;
      end
    end
    m_blackout = flush;
  endtask

  task automatic cycle();
    #2;
    check_outputs();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    issue_valid = 0; issue_rs1 = 0; issue_rs2 = 0; issue_rd = 0;
    issue_rs1_used = 0; issue_rs2_used = 0; issue_RegWrite = 0;
    wb_valid = 0; wb_RegWrite = 0; wb_rd = 0; flush = 0;
  endtask

  task automatic set_issue(input bit v, input int rd, input bit rw, input int rs1, input bit u1);
    issue_valid = v; issue_rd = 5'(rd); issue_RegWrite = rw;
    issue_rs1 = 5'(rs1); issue_rs1_used = u1;
    issue_rs2 = 0; issue_rs2_used = 0;
  endtask

  task automatic set_wb(input bit v, input int rd);
    wb_valid = v; wb_RegWrite = v; wb_rd = 5'(rd);
  endtask

  initial begin
    idle();
    rst = 1;
    model_reset();
    repeat (2) @(negedge clk);
    #2;
    check("rst_pending", 64'(pending_mask), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_err", 64'(err_underflow), 64'd0);
    check("rst_stall", 64'(stall_cycles), 64'd0);
    check("rst_ready", 64'(issue_ready), 64'd1);
    @(negedge clk);
    rst = 0;

    // RAW on a pending load destination, released the cycle after retire
    set_issue(1, 5, 1, 0, 0); cycle();
    set_issue(1, 6, 1, 5, 1); cycle(); cycle();
    set_wb(1, 5); cycle();
    set_wb(0, 0); cycle();
    idle(); set_wb(1, 6); cycle();

    // x0 is never tracked
    idle(); set_issue(1, 0, 1, 0, 0); cycle();
    set_issue(1, 1, 0, 0, 1); cycle();

    // WAW saturation on x7, then retire and simultaneous issue+retire
    idle();
    repeat (3) begin set_issue(1, 7, 1, 0, 0); cycle(); end
    set_issue(1, 7, 1, 0, 0); cycle(); cycle();
    set_wb(1, 7); cycle();
    cycle();
    set_wb(1, 7); cycle();
    idle(); cycle();

    // Flush with an issue present, then the one-cycle blackout
    idle(); set_issue(1, 3, 1, 0, 0); cycle();
    set_issue(1, 9, 1, 0, 0); cycle();
    set_issue(1, 10, 1, 0, 0); flush = 1; set_wb(1, 3); cycle();
    flush = 0; set_issue(1, 11, 1, 0, 0); set_wb(1, 9); cycle();
    idle(); cycle();

    // Retire with nothing pending
    set_wb(1, 12); cycle();
    idle(); cycle(); cycle();

    // Asynchronous reset in the middle of a stall
    set_issue(1, 4, 1, 0, 0); cycle();
    set_issue(1, 8, 1, 4, 1); cycle();
    #2;
    check("pre_arst_pending4", 64'(pending_mask[4]), 64'd1);
    #1 rst = 1;
    #1;
    model_reset();
    check("arst_pending", 64'(pending_mask), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_err", 64'(err_underflow), 64'd0);
    check("arst_stall", 64'(stall_cycles), 64'd0);
    check("arst_ready", 64'(issue_ready), 64'd1);
    @(negedge clk);
    rst = 0;
    idle();
    cycle();

    // Randomized traffic against the reference model
    for (int n = 0; n < 3000; n++) begin
      issue_valid    = ($urandom_range(0, 9) < 7);
      issue_rd       = 5'($urandom_range(0, 9));
      issue_RegWrite = ($urandom_range(0, 9) < 7);
      issue_rs1      = 5'($urandom_range(0, 9));
      issue_rs2      = 5'($urandom_range(0, 9));
      issue_rs1_used = $urandom_range(0, 1) == 1;
      issue_rs2_used = $urandom_range(0, 1) == 1;
      wb_valid       = ($urandom_range(0, 9) < 5);
      wb_RegWrite    = ($urandom_range(0, 9) < 9);
      wb_rd          = 5'($urandom_range(0, 9));
      flush          = ($urandom_range(0, 39) == 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
